// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared state encoding and operand-width legality check for seq_multiplier.
package seq_multiplier_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  function automatic bit width_ok(input int w);
    return w >= WIDTH_MIN && w <= WIDTH_MAX;
  endfunction
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/operand request and busy/done/product response bundle.
interface seq_multiplier_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, a, b, input busy, done, product);
  modport slave (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per cycle, sign handled as magnitude plus final negation.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic clk,
  input logic rst_n,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  if (!width_ok(WIDTH)) begin : g_width_bad
    $error("seq_multiplier: WIDTH out of range");
  end
  state_t state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, a_mag, b_mag;
  logic [2*WIDTH:0] acc, acc_add, acc_nxt;
  logic [2*WIDTH-1:0] product, prod_nxt;
  logic [CW-1:0] cnt;
  logic neg, accept, last;
  always_comb begin
    accept = bus.start && state != RUN;
    last = cnt == CW'(WIDTH - 1);
    a_mag = (SIGNED && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (SIGNED && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // the upper slice is one bit wider than the multiplicand so the add never overflows before the shift
    acc_add = {acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0), acc[WIDTH-1:0]};
    acc_nxt = acc_add >> 1;
    prod_nxt = neg ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];
    state_nxt = accept ? RUN : (state == RUN && last) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand <= a_mag;
        mplier <= b_mag;
        acc <= '0;
        cnt <= '0;
        neg <= SIGNED & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (last) product <= prod_nxt;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.product = product;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of 2-bit unsigned, 8-bit unsigned and 8-bit signed multipliers.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic cur_done, cur_busy;
  logic [15:0] cur_prod;
  seq_multiplier_if #(.WIDTH(2)) i2 ();
  seq_multiplier_if #(.WIDTH(8)) i8u ();
  seq_multiplier_if #(.WIDTH(8)) i8s ();
  seq_multiplier #(.WIDTH(2), .SIGNED(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  seq_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u8u (.clk(clk), .rst_n(rst_n), .bus(i8u.slave));
  seq_multiplier #(.WIDTH(8), .SIGNED(1'b1)) u8s (.clk(clk), .rst_n(rst_n), .bus(i8s.slave));
  always #5 clk = ~clk;
  always_comb begin
    cur_done = sel == 0 ? i2.done : sel == 1 ? i8u.done : i8s.done;
    cur_busy = sel == 0 ? i2.busy : sel == 1 ? i8u.busy : i8s.busy;
    cur_prod = sel == 0 ? {12'd0, i2.product} : sel == 1 ? i8u.product : i8s.product;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int s, input logic st, input logic [7:0] x, input logic [7:0] y);
    if (s == 0) begin
      i2.start = st;
      i2.a = x[1:0];
      i2.b = y[1:0];
    end else if (s == 1) begin
      i8u.start = st;
      i8u.a = x;
      i8u.b = y;
    end else begin
      i8s.start = st;
      i8s.a = x;
      i8s.b = y;
    end
  endtask
  task automatic op(input int s, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                    input int w, input string tag);
    int cyc, nb;
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, x, y);
    @(negedge clk);
    drive(s, 1'b0, ~x, ~y);
    cyc = 0;
    nb = 0;
    while (!cur_done && cyc < 40) begin
      if (cur_busy) nb++;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, w);
    check({tag, " busy cycles"}, nb, w);
    check({tag, " product"}, cur_prod, exp);
    @(negedge clk);
    check({tag, " done pulse"}, cur_done, 1'b0);
    check({tag, " product hold"}, cur_prod, exp);
  endtask
  initial begin
    int cyc, dn;
    drive(0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 8'd0, 8'd0);
    drive(2, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    check("reset busy", i8u.busy, 1'b0);
    check("reset done", i8u.done, 1'b0);
    check("reset product", i8u.product, 16'd0);
    check("reset w2 product", i2.product, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        op(0, 8'(i), 8'(j), 16'(i * j), 2, $sformatf("w2 %0d*%0d", i, j));
    op(1, 8'd255, 8'd255, 16'd65025, 8, "u 255*255");
    op(2, 8'hFD, 8'd5, 16'hFFF1, 8, "s -3*5");
    op(2, 8'h80, 8'h80, 16'h4000, 8, "s -128*-128");
    op(2, 8'h80, 8'h7F, 16'hC080, 8, "s -128*127");
    op(2, 8'h00, 8'hFF, 16'h0000, 8, "s 0*-1");
    op(2, 8'h7F, 8'h7F, 16'h3F01, 8, "s 127*127");
    sel = 1;
    @(negedge clk);
    drive(1, 1'b1, 8'd10, 8'd10);
    @(negedge clk);
    drive(1, 1'b0, 8'd0, 8'd0);
    cyc = 0;
    while (!cur_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) drive(1, 1'b1, 8'd7, 8'd7);
      else drive(1, 1'b0, 8'd0, 8'd0);
    end
    check("ignore latency", cyc, 8);
    check("ignore product", cur_prod, 16'd100);
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (cur_done || cur_busy) dn++;
    end
    check("ignore extra activity", dn, 0);
    @(negedge clk);
    drive(1, 1'b1, 8'd200, 8'd200);
    @(negedge clk);
    drive(1, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", cur_busy, 1'b0);
    check("abort done", cur_done, 1'b0);
    check("abort product", cur_prod, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (cur_done || cur_busy) dn++;
    end
    check("abort no done", dn, 0);
    op(1, 8'd6, 8'd7, 16'd42, 8, "u 6*7");
    @(negedge clk);
    drive(1, 1'b1, 8'd2, 8'd3);
    @(negedge clk);
    drive(1, 1'b1, 8'd4, 8'd5);
    cyc = 0;
    while (!cur_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b first latency", cyc, 8);
    check("b2b first product", cur_prod, 16'd6);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      drive(1, 1'b0, 8'd9, 8'd9);
    end while (!cur_done && cyc < 40);
    check("b2b period", cyc, 9);
    check("b2b second product", cur_prod, 16'd20);
    @(negedge clk);
    check("b2b idle", cur_busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
